// File: rtl/uart_io_pkg.sv
// Shared types and constants for the word-level UART I/O engine and the core's IN/OUT decode.
// No logic here; latency and backpressure belong to the modules that import it.
package uart_io_pkg;

  localparam int BYTE_W = 8;

  localparam logic [5:0] OP_IN  = 6'b111011;
  localparam logic [5:0] OP_OUT = 6'b111100;

  typedef enum logic [1:0] {
    IDLE,
    RX_GATHER,
    TX_SEND,
    DONE
  } io_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a combinational head read. Latency: a push is poppable from the next cycle.
// Backpressure: a push when full is dropped unless a pop happens in the same cycle.
module byte_fifo
  import uart_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        din,
  input  logic                     pop,
  output logic [BYTE_W-1:0]        data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot at the edge, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_word_io.sv
// Word-level IN/OUT engine over a byte UART. Latency: IN with bytes buffered completes N+1 cycles after in_req; OUT acks N+1 cycles after out_req.
// Backpressure: RX bytes buffered in a FIFO (overflow is sticky); TX bytes held on tx_data until tx_ready.
module uart_word_io
  import uart_io_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [7:0]                     tx_data,
  output logic                           tx_enable,
  input  logic                           tx_ready,
  input  logic                           in_req,
  output logic [8*WORD_BYTES-1:0]        in_data,
  output logic                           in_valid,
  input  logic                           out_req,
  input  logic [8*WORD_BYTES-1:0]        out_data,
  output logic                           out_done,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    rx_count,
  output logic                           rx_overflow
);

  localparam int WW = BYTE_W * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  io_state_t          state_q, state_d;
  logic [CW-1:0]      k_q;
  logic               dir_in_q;
  logic [WW-1:0]      acc_q;
  logic [WW-1:0]      acc_next;
  logic [WW-1:0]      in_word_q;
  logic [WW-1:0]      tx_word_q;
  logic [BYTE_W-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               overflow_q;
  logic               tx_acc;

  // Bit position of byte k on the wire; RX and TX share this ordering.
  function automatic int slot_lsb(input logic [CW-1:0] k);
    return BYTE_W * (MSB_FIRST ? (WORD_BYTES - 1 - int'(k)) : int'(k));
  endfunction

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (fifo_pop),
    .data  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    tx_enable = 1'b0;
    tx_data   = '0;
    in_valid  = 1'b0;
    out_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req)       state_d = RX_GATHER;
        else if (out_req) state_d = TX_SEND;
      end
      RX_GATHER: begin
        fifo_pop = !fifo_empty;
        if (!fifo_empty && k_q == LAST) state_d = DONE;
      end
      TX_SEND: begin
        tx_enable = 1'b1;
        tx_data   = tx_word_q[slot_lsb(k_q) +: BYTE_W];
        if (tx_ready && k_q == LAST) state_d = DONE;
      end
      DONE: begin
        in_valid = dir_in_q;
        out_done = !dir_in_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_next = acc_q;
    acc_next[slot_lsb(k_q) +: BYTE_W] = fifo_head;
  end

  assign tx_acc      = tx_enable && tx_ready;
  assign in_data     = in_word_q;
  assign busy        = (state_q != IDLE);
  assign rx_overflow = overflow_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k_q        <= '0;
      dir_in_q   <= 1'b0;
      acc_q      <= '0;
      in_word_q  <= '0;
      tx_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rx_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      if (state_q == IDLE) begin
        k_q <= '0;
        if (in_req) begin
          dir_in_q <= 1'b1;
          acc_q    <= '0;
        end else if (out_req) begin
          dir_in_q  <= 1'b0;
          tx_word_q <= out_data;
        end
      end
      // The finished word goes straight to in_data so it is valid in the DONE cycle.
      if (fifo_pop) begin
        acc_q <= acc_next;
        k_q   <= k_q + CW'(1);
        if (k_q == LAST) in_word_q <= acc_next;
      end
      if (tx_acc) k_q <= k_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_word_io.sv
// Randomised bench for uart_word_io: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-based model of the FIFO and the IN/OUT transactions.
module tb_uart_word_io;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int WW    = 8 * N;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic          in_req = 1'b0;
  logic          out_req = 1'b0;
  logic [WW-1:0] out_data = '0;

  logic [7:0]      msb_tx_data, lsb_tx_data;
  logic            msb_tx_en, lsb_tx_en;
  logic [WW-1:0]   msb_in_data, lsb_in_data;
  logic            msb_in_vld, lsb_in_vld;
  logic            msb_out_done, lsb_out_done;
  logic            msb_busy, lsb_busy;
  logic [CNTW-1:0] msb_rx_count, lsb_rx_count;
  logic            msb_ovf, lsb_ovf;

  uart_word_io #(.WORD_BYTES(N), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(msb_tx_data), .tx_enable(msb_tx_en), .tx_ready(tx_ready),
    .in_req(in_req), .in_data(msb_in_data), .in_valid(msb_in_vld),
    .out_req(out_req), .out_data(out_data), .out_done(msb_out_done),
    .busy(msb_busy), .rx_count(msb_rx_count), .rx_overflow(msb_ovf)
  );

  uart_word_io #(.WORD_BYTES(N), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(lsb_tx_data), .tx_enable(lsb_tx_en), .tx_ready(tx_ready),
    .in_req(in_req), .in_data(lsb_in_data), .in_valid(lsb_in_vld),
    .out_req(out_req), .out_data(out_data), .out_done(lsb_out_done),
    .busy(lsb_busy), .rx_count(lsb_rx_count), .rx_overflow(lsb_ovf)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: transaction-level view of the block.
  logic [7:0]    mdl_q[$];
  bit            mdl_ovf;
  bit            mdl_gather;
  int            mdl_k;
  logic [WW-1:0] mdl_msb_acc, mdl_lsb_acc;
  logic [WW-1:0] mdl_exp_msb, mdl_exp_lsb;
  bit            mdl_in_done;
  bit            mdl_tx;
  int            mdl_tk;
  logic [WW-1:0] mdl_word;
  bit            mdl_out_done;

  logic [7:0]    tx_seen[$];
  logic [WW-1:0] last_msb_word, last_lsb_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_busy();
    return mdl_gather || mdl_tx || mdl_in_done || mdl_out_done;
  endfunction

  task automatic mdl_clear();
    mdl_q.delete();
    mdl_ovf = 0; mdl_gather = 0; mdl_k = 0; mdl_in_done = 0;
    mdl_tx = 0; mdl_tk = 0; mdl_out_done = 0;
    mdl_msb_acc = '0; mdl_lsb_acc = '0; mdl_exp_msb = '0; mdl_exp_lsb = '0;
    mdl_word = '0;
  endtask

  task automatic mdl_edge();
    bit   idle;
    bit   pop;
    int   pre;
    logic [7:0] b;
    idle = !mdl_busy();
    pre  = mdl_q.size();
    pop  = mdl_gather && pre > 0;
    mdl_in_done  = 0;
    mdl_out_done = 0;
    if (pop) begin
      b = mdl_q.pop_front();
      mdl_msb_acc = (mdl_msb_acc << 8) | WW'(b);
      mdl_lsb_acc = mdl_lsb_acc | (WW'(b) << (8 * mdl_k));
      mdl_k++;
      if (mdl_k == N) begin
        mdl_gather  = 0;
        mdl_in_done = 1;
        mdl_exp_msb = mdl_msb_acc;
        mdl_exp_lsb = mdl_lsb_acc;
      end
    end
    if (mdl_tx && tx_ready) begin
      mdl_tk++;
      if (mdl_tk == N) begin
        mdl_tx = 0;
        mdl_out_done = 1;
      end
    end
    if (rx_valid) begin
      if (pre < DEPTH || pop) mdl_q.push_back(rx_data);
      else mdl_ovf = 1;
    end
    if (idle && in_req) begin
      mdl_gather = 1; mdl_k = 0; mdl_msb_acc = '0; mdl_lsb_acc = '0;
    end else if (idle && out_req) begin
      mdl_tx = 1; mdl_tk = 0; mdl_word = out_data;
    end
  endtask

  task automatic check_all();
    chk("msb rx_count", 64'(msb_rx_count), 64'(mdl_q.size()));
    chk("lsb rx_count", 64'(lsb_rx_count), 64'(mdl_q.size()));
    chk("msb rx_overflow", 64'(msb_ovf), 64'(mdl_ovf));
    chk("lsb rx_overflow", 64'(lsb_ovf), 64'(mdl_ovf));
    chk("msb busy", 64'(msb_busy), 64'(mdl_busy()));
    chk("lsb busy", 64'(lsb_busy), 64'(mdl_busy()));
    chk("msb in_valid", 64'(msb_in_vld), 64'(mdl_in_done));
    chk("lsb in_valid", 64'(lsb_in_vld), 64'(mdl_in_done));
    chk("msb in_data", 64'(msb_in_data), 64'(mdl_exp_msb));
    chk("lsb in_data", 64'(lsb_in_data), 64'(mdl_exp_lsb));
    chk("msb out_done", 64'(msb_out_done), 64'(mdl_out_done));
    chk("lsb out_done", 64'(lsb_out_done), 64'(mdl_out_done));
    chk("msb tx_enable", 64'(msb_tx_en), 64'(mdl_tx));
    chk("lsb tx_enable", 64'(lsb_tx_en), 64'(mdl_tx));
    if (mdl_tx) begin
      chk("msb tx_data", 64'(msb_tx_data), 64'(mdl_word[8*(N-1-mdl_tk) +: 8]));
      chk("lsb tx_data", 64'(lsb_tx_data), 64'(mdl_word[8*mdl_tk +: 8]));
    end
  endtask

  // One clock: inputs already driven; model follows the edge; outputs checked 1 unit later.
  task automatic step();
    if (msb_tx_en && tx_ready) tx_seen.push_back(msb_tx_data);
    @(posedge CLK);
    if (RST_N) mdl_edge();
    #1;
    check_all();
    if (msb_in_vld) last_msb_word = msb_in_data;
    if (lsb_in_vld) last_lsb_word = lsb_in_data;
    rx_valid = 1'b0;
    in_req   = 1'b0;
    out_req  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    mdl_clear();
    check_all();
    chk("msb tx_data reset", 64'(msb_tx_data), 64'h0);
    chk("lsb tx_data reset", 64'(lsb_tx_data), 64'h0);
    @(posedge CLK);
    #1;
    check_all();
    rx_valid = 1'b0; in_req = 1'b0; out_req = 1'b0;
    RST_N = 1'b1;
  endtask

  task automatic run_in(input int cycles);
    in_req = 1'b1;
    step();
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    logic [7:0] exp_tx[4];
    int cyc;
    exp_tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    last_msb_word = '0;
    last_lsb_word = '0;

    do_reset();

    // Basic IN, both byte orders.
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    run_in(N + 2);
    chk("in word msb-first", 64'(last_msb_word), 64'h12345678);
    chk("in word lsb-first", 64'(last_lsb_word), 64'h78563412);

    // OUT with tx_ready low three cycles per byte.
    tx_seen.delete();
    tx_ready = 1'b0;
    out_data = 32'hDEADBEEF;
    out_req  = 1'b1;
    step();
    cyc = 0;
    while (mdl_busy() && cyc < 40) begin
      tx_ready = ((cyc % 4) == 3);
      step();
      cyc++;
    end
    chk("out finished in budget", 64'(cyc < 40), 64'h1);
    chk("tx byte count", 64'(tx_seen.size()), 64'(N));
    for (int i = 0; i < N && i < tx_seen.size(); i++)
      chk("tx byte order", 64'(tx_seen[i]), 64'(exp_tx[i]));
    tx_ready = 1'b0;

    // Overflow: 17 bytes into a 16-deep FIFO, then IN returns the first four.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'(8'hA0 + i));
    chk("count at full", 64'(msb_rx_count), 64'(DEPTH));
    chk("overflow set", 64'(msb_ovf), 64'h1);
    run_in(N + 2);
    chk("in word after overflow", 64'(last_msb_word), 64'hA0A1A2A3);

    // Simultaneous requests at full, with push+pop at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    in_req = 1'b1; out_req = 1'b1; out_data = $urandom; tx_ready = 1'b1;
    step();
    for (int i = 0; i < N; i++) push_byte(8'($urandom));
    for (int i = 0; i < 3; i++) step();
    chk("count after push+pop at full", 64'(msb_rx_count), 64'(DEPTH));
    chk("no overflow on push+pop", 64'(msb_ovf), 64'h0);

    // Reset in the middle of an IN.
    do_reset();
    for (int i = 0; i < N; i++) push_byte(8'(8'h10 + i));
    in_req = 1'b1;
    step();
    step();
    step();
    do_reset();
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    run_in(N + 2);
    chk("in word after reset", 64'(last_msb_word), 64'hC1C2C3C4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 1) == 1);
      if (!mdl_busy() && $urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0: in_req = 1'b1;
          1: begin out_req = 1'b1; out_data = $urandom; end
          default: begin in_req = 1'b1; out_req = 1'b1; out_data = $urandom; end
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
